// File: rtl/csa_stream_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : csa_stream_accumulator
// Brief    : Streaming multi-operand modular adder; carry-save accumulation
//            followed by a chunked carry-propagate resolve pass.
// Revision : 1.0 - initial release
// ============================================================================
module csa_stream_accumulator #(
    parameter int LEN   = 256,
    parameter int N_IN  = 2,
    parameter int CPA_W = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic                in_last_i,
    input  logic [N_IN*LEN-1:0] in_data_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [LEN-1:0]      out_data_o
);

    localparam int c_NUM_CHUNKS = LEN / CPA_W;
    localparam int c_IDX_W      = (c_NUM_CHUNKS > 1) ? $clog2(c_NUM_CHUNKS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NUM_CHUNKS - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

    typedef enum logic [1:0] {
        S_ACC     = 2'd0,
        S_RESOLVE = 2'd1,
        S_OUT     = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_first;
    logic [LEN-1:0]     r_ps;
    logic [LEN-1:0]     r_cs;
    logic [LEN-1:0]     r_res;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_carry;

    logic [LEN-1:0]     w_ps0;
    logic [LEN-1:0]     w_cs0;
    logic [LEN-1:0]     w_op0;
    logic [LEN-1:0]     w_s1;
    logic [LEN-1:0]     w_c1;
    logic [LEN-1:0]     w_ps_nxt;
    logic [LEN-1:0]     w_cs_nxt;
    logic [CPA_W:0]     w_sum;
    logic [LEN-1:0]     w_res_nxt;

    // A fresh packet sees an all-zero accumulator without spending a clear cycle.
    assign w_ps0 = r_first ? '0 : r_ps;
    assign w_cs0 = r_first ? '0 : r_cs;
    assign w_op0 = in_data_i[0 +: LEN];

    assign w_s1 = w_ps0 ^ w_cs0 ^ w_op0;
    assign w_c1 = {(w_ps0[LEN-2:0] & w_cs0[LEN-2:0]) |
                   (w_ps0[LEN-2:0] & w_op0[LEN-2:0]) |
                   (w_cs0[LEN-2:0] & w_op0[LEN-2:0]), 1'b0};

    generate
        if (N_IN == 2) begin : g_two_level
            logic [LEN-1:0] w_op1;
            assign w_op1    = in_data_i[LEN +: LEN];
            assign w_ps_nxt = w_s1 ^ w_c1 ^ w_op1;
            assign w_cs_nxt = {(w_s1[LEN-2:0] & w_c1[LEN-2:0]) |
                               (w_s1[LEN-2:0] & w_op1[LEN-2:0]) |
                               (w_c1[LEN-2:0] & w_op1[LEN-2:0]), 1'b0};
        end else begin : g_one_level
            assign w_ps_nxt = w_s1;
            assign w_cs_nxt = w_c1;
        end
    endgenerate

    // Resolve walks LSB chunk first: ps/cs shift down, the result fills from the top.
    assign w_sum     = {1'b0, r_ps[CPA_W-1:0]} + {1'b0, r_cs[CPA_W-1:0]}
                     + {{CPA_W{1'b0}}, r_carry};
    assign w_res_nxt = (r_res >> CPA_W) | (LEN'(w_sum[CPA_W-1:0]) << (LEN - CPA_W));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_ACC;
            r_first <= 1'b1;
            r_ps    <= '0;
            r_cs    <= '0;
            r_res   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
        end else begin
            case (r_state)
                S_ACC: begin
                    if (in_valid_i) begin
                        r_ps    <= w_ps_nxt;
                        r_cs    <= w_cs_nxt;
                        r_first <= 1'b0;
                        if (in_last_i) begin
                            r_state <= S_RESOLVE;
                            r_idx   <= '0;
                            r_carry <= 1'b0;
                        end
                    end
                end
                S_RESOLVE: begin
                    r_res   <= w_res_nxt;
                    r_ps    <= r_ps >> CPA_W;
                    r_cs    <= r_cs >> CPA_W;
                    r_carry <= w_sum[CPA_W];
                    r_idx   <= r_idx + c_IDX_ONE;
                    if (r_idx == c_LAST_IDX) begin
                        r_state <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready_i) begin
                        r_first <= 1'b1;
                        r_state <= S_ACC;
                    end
                end
                default: r_state <= S_ACC;
            endcase
        end
    end

    assign in_ready_o  = (r_state == S_ACC);
    assign out_valid_o = (r_state == S_OUT);
    assign out_data_o  = r_res;

endmodule
`default_nettype wire

// File: doc/csa_stream_accumulator.md
# csa_stream_accumulator

Multi-operand accumulator built around 3:2 carry-save compression. It sums a packet of LEN-bit operands, N_IN per beat, modulo 2^LEN. The accumulator stays in redundant partial-sum/carry-save form while the packet streams in, then resolves to binary with a chunked carry-propagate pass of CPA_W bits per cycle. It sits between operand generators and the correlated-randomness output stage, wherever wide modular sums are needed without a full-width adder on the critical path.

## Interface
- LEN, 256, operand and result width; must be a multiple of CPA_W.
- N_IN, 2, operands per input beat; legal values are 1 and 2.
- CPA_W, 64, carry-propagate chunk width per resolve cycle; R = LEN/CPA_W resolve cycles.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- in_valid_i  input  1  input beat valid.
- in_ready_o  output  1  block can accept a beat.
- in_last_i  input  1  beat is the final beat of the packet; qualified by in_valid_i.
- in_data_i  input  N_IN*LEN  operands; operand k is bits [k*LEN +: LEN].
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  consumer accepts the result.
- out_data_o  output  LEN  packet sum mod 2^LEN.

## Operation
- Internal registers:
  - ps, cs (LEN each), the redundant accumulator. cs is stored pre-shifted: majority terms shifted left by 1, MSB dropped.
  - first flag, set at reset and after each output handshake.
  - chunk index and carry bit for the resolve pass.
  - res (LEN), drives out_data_o.
- FSM states are ACC, RESOLVE and OUT. Reset goes to ACC.
- ACC:
  - in_ready_o = 1.
  - On in_valid_i && in_ready_o, fold the operands into the accumulator. If first = 1, the accumulator is treated as zero.
  - N_IN=1: one CSA level (ps, cs, op0).
  - N_IN=2: two levels, (ps, cs, op0) then (s1, c1, op1).
  - Clear first on every accepted beat.
  - If in_last_i, go to RESOLVE with chunk index = 0 and carry = 0.
- RESOLVE:
  - in_ready_o = 0.
  - Each cycle, compute res chunk i = ps chunk i + cs chunk i + carry. The carry-out becomes the next carry.
  - After chunk R-1, discard the carry (mod 2^LEN) and go to OUT.
- OUT:
  - out_valid_o = 1 and in_ready_o = 0.
  - out_data_o is held stable until out_ready_i.
  - On handshake: set first = 1 and go to ACC.
- Single-beat packets (first beat has in_last_i = 1) are legal.
- in_valid_i is ignored outside ACC. in_last_i is ignored without in_valid_i.
- Reset at any point:
  - Aborts the packet.
  - The next cycle is ACC with first = 1, out_valid_o = 0 and res = 0. No residue from the aborted packet survives.
- Reset values: in_ready_o = 1, out_valid_o = 0, out_data_o = 0.

## Timing
- Accepted beats: one per cycle, back-to-back, with no bubbles while in ACC.
- Last beat accepted at edge t:
  - RESOLVE occupies cycles t+1 .. t+R.
  - out_valid_o rises at t+R+1.
- Output handshake at edge c: in_ready_o = 1 at c+1.
- Throughput is one packet per (beats + R + 1) cycles minimum.
- Critical path:
  - ACC: N_IN CSA levels (XOR/majority depth, width-independent).
  - RESOLVE: one CPA_W-bit add plus carry-in.
- No combinational path from any input to any output. in_ready_o and out_valid_o are decoded from the state register only.

## Test plan
All scenarios use LEN=16, N_IN=2, CPA_W=4 (R=4).
- **Basic single beat.** One beat {0x0005, 0x0003} with last, accepted at t.
  - out_valid_o = 1 at t+5, out_data_o = 0x0008.
  - in_ready_o = 0 from t+1 until the handshake.
- **Inter-chunk carry.** Beat {0x0001, 0x0FFF} with last -> 0x1000. Then {0x0001, 0xFFFF} -> 0x0000 (wrap, carry discarded).
- **Multi-beat wrap.** Beats {0x0001, 0xFFFF}, {0x0000, 0x0001} last -> 0x0001.
- **Backpressure.**
  - Hold out_ready_i = 0 for 10 cycles after out_valid_o. Required: out_valid_o and out_data_o stay stable, in_ready_o stays 0, and in_valid_i pulses during this window have no effect.
  - Release out_ready_i. Required: in_ready_o = 1 the next cycle.
- **Reset mid-operation.** Assert rst_i in RESOLVE cycle 2.
  - Next cycle: out_valid_o = 0, in_ready_o = 1, out_data_o = 0.
  - A following packet {0x0002, 0x0002} -> 0x0004, with no residue from the aborted packet.
- **Random soak.** 2000 packets of 1–50 random beats, random in_valid_i and out_ready_i gaps. Every result must equal the reference-model sum mod 2^16, and packets must never be lost or duplicated.
